// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the fetch PC, runs the imem req/ack handshake and buffers
// fetched words for decode. Optional misaligned-redirect fault: FETCH_MISALIGN_CHECK_EN.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halt,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic [4:0]  rs1_reg_offset,
  output logic [4:0]  rs2_reg_offset,
  output logic [4:0]  rd_reg_offset,
  output logic        freeze_pc,
  output logic        fetch_fault
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StReq, StDiscard} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     buf_instr_q [DEPTH];
  logic [31:0]     buf_pc_q    [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            push, pop, fault;
  logic [31:0]     redirect_aligned;
  logic [31:0]     head_instr;

  assign redirect_aligned = {redirect_pc[31:2], 2'b00};

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
      fault_q <= 1'b1;
    end
  end
  assign fault = fault_q;
`else
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^redirect_pc[1:0];
  assign fault = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    push       = 1'b0;
    case (state_q)
      StIdle: begin
        // Counting only committed entries guarantees the eventual push has a free slot.
        if (!halt && !redirect && !fault && (count_q < DepthCnt)) begin
          state_d = StReq;
          addr_d  = fetch_pc_q;
        end
      end
      StReq: begin
        if (imem_ack) begin
          state_d = StIdle;
          if (!redirect) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end else if (redirect) begin
          state_d = StDiscard;
        end
      end
      StDiscard: begin
        if (imem_ack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (redirect) begin
      fetch_pc_d = redirect_aligned;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr_q[wr_ptr_q] <= imem_rdata;
      buf_pc_q[wr_ptr_q]    <= addr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (redirect) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (!push && pop) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  assign head_instr     = buf_instr_q[rd_ptr_q];
  assign instr_valid    = (count_q != '0) && !halt && !fault;
  assign pop            = instr_valid && instr_ready;
  assign instr_out      = instr_valid ? head_instr : 32'd0;
  assign instr_pc       = instr_valid ? buf_pc_q[rd_ptr_q] : 32'd0;
  assign rs1_reg_offset = instr_out[19:15];
  assign rs2_reg_offset = instr_out[24:20];
  assign rd_reg_offset  = instr_out[11:7];
  assign freeze_pc      = !pop;
  assign imem_req       = (state_q != StIdle);
  assign imem_addr      = addr_q;
  assign fetch_fault    = fault;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: a reactive memory, a queue-based model of the instruction buffer checked
// every cycle, and directed scenarios with literal expectations.
module tb_inst_fetch;

  localparam int DEPTH = 2;

  logic        clk, rst_n, halt, redirect, imem_req, imem_ack, instr_valid, instr_ready;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, instr_out, instr_pc;
  logic [4:0]  rs1_reg_offset, rs2_reg_offset, rd_reg_offset;
  logic        freeze_pc, fetch_fault;

  inst_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .halt(halt), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_out(instr_out),
    .instr_pc(instr_pc), .rs1_reg_offset(rs1_reg_offset), .rs2_reg_offset(rs2_reg_offset),
    .rd_reg_offset(rd_reg_offset), .freeze_pc(freeze_pc), .fetch_fault(fetch_fault)
  );

  typedef struct packed {logic [31:0] instr; logic [31:0] pc;} ent_t;

  int          total = 0, bad = 0;
  int          mem_lat = 1;
  bit          const_data = 0, chk_en = 0;
  ent_t        q[$];
  logic [31:0] popped[$], req_log[$];
  logic [31:0] next_fetch;
  bit          discarding, fault_exp;
  int          ack_cnt;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time exceeded, required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: event did not happen within cycle budget", name);
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return 32'h0020_8033 ^ {a[9:2], 24'h0};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Memory: acks the L-th cycle a request is held, then idles one cycle.
  initial begin
    int waitc;
    waitc = 0;
    imem_ack = 0;
    imem_rdata = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n || imem_ack) begin
        imem_ack = 0;
        waitc = 0;
      end else if (imem_req) begin
        waitc++;
        if (waitc >= mem_lat) begin
          imem_ack = 1;
          imem_rdata = const_data ? 32'h0020_8033 : data_of(imem_addr);
        end
      end
    end
  end

  // Model and per-cycle compare; the update reflects what the coming posedge does.
  initial begin
    bit prev_req, prev_ack, prev_halt, prev_redirect, exp_valid, new_req, pop_e;
    logic [31:0] prev_addr;
    prev_req = 0; prev_ack = 0; prev_halt = 0; prev_redirect = 0; prev_addr = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete(); popped.delete(); req_log.delete();
        next_fetch = 32'h0; discarding = 0; fault_exp = 0; ack_cnt = 0;
        prev_req = 0; prev_ack = 0; prev_halt = 0; prev_redirect = 0;
        if (chk_en) begin
          chk("rst_req", {31'd0, imem_req}, 32'd0);
          chk("rst_addr", imem_addr, 32'h0);
          chk("rst_valid", {31'd0, instr_valid}, 32'd0);
          chk("rst_out", instr_out, 32'd0);
          chk("rst_pc", instr_pc, 32'd0);
          chk("rst_freeze", {31'd0, freeze_pc}, 32'd1);
        end
      end else if (chk_en) begin
        exp_valid = (q.size() != 0) && !halt && !fault_exp;
        chk("valid", {31'd0, instr_valid}, {31'd0, exp_valid});
        if (exp_valid) begin
          chk("instr_out", instr_out, q[0].instr);
          chk("instr_pc", instr_pc, q[0].pc);
          chk("rs1", {27'd0, rs1_reg_offset}, {27'd0, q[0].instr[19:15]});
          chk("rs2", {27'd0, rs2_reg_offset}, {27'd0, q[0].instr[24:20]});
          chk("rd", {27'd0, rd_reg_offset}, {27'd0, q[0].instr[11:7]});
        end
        chk("freeze", {31'd0, freeze_pc}, {31'd0, !(exp_valid && instr_ready)});
        chk("fault", {31'd0, fetch_fault}, {31'd0, fault_exp});
        new_req = imem_req && (!prev_req || prev_ack);
        if (new_req) begin
          req_log.push_back(imem_addr);
          chk("req_addr", imem_addr, next_fetch);
          chk("req_gated", {31'd0, prev_halt || prev_redirect || fault_exp}, 32'd0);
        end else if (imem_req && prev_req) begin
          chk("addr_hold", imem_addr, prev_addr);
        end
        chk("space", {31'd0, (q.size() + int'(imem_req && !discarding)) <= DEPTH}, 32'd1);
        pop_e = exp_valid && instr_ready;
        if (pop_e) begin
          popped.push_back(q[0].pc);
          void'(q.pop_front());
        end
        if (imem_req && imem_ack) begin
          ack_cnt++;
          if (!discarding && !redirect) begin
            q.push_back('{instr: imem_rdata, pc: imem_addr});
            next_fetch = next_fetch + 32'd4;
          end
        end
        if (redirect) begin
          q.delete();
          next_fetch = {redirect_pc[31:2], 2'b00};
          discarding = imem_req && !imem_ack;
`ifdef FETCH_MISALIGN_CHECK_EN
          if (redirect_pc[1:0] != 2'b00) fault_exp = 1;
`endif
        end else if (imem_req && imem_ack) begin
          discarding = 0;
        end
        prev_req = imem_req; prev_ack = imem_ack; prev_halt = halt;
        prev_redirect = redirect; prev_addr = imem_addr;
      end
    end
  end

  task automatic reset_dut();
    halt = 0;
    redirect = 0;
    rst_n = 0;
    #1;
    chk("async_rst_req", {31'd0, imem_req}, 32'd0);
    chk("async_rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("async_rst_fault", {31'd0, fetch_fault}, 32'd0);
    cyc();
    cyc();
    rst_n = 1;
  endtask

  task automatic wait_pops(input int n, input string name);
    for (int i = 0; i < 100; i++) begin
      if (popped.size() >= n) return;
      cyc();
    end
    timeout(name);
  endtask

  task automatic wait_reqs(input int n, input string name);
    for (int i = 0; i < 100; i++) begin
      if (req_log.size() >= n) return;
      cyc();
    end
    timeout(name);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 50; i++) begin
      if (!imem_req) return;
      cyc();
    end
    timeout(name);
  endtask

  initial begin
    int base, pbase;
    bit hit;
    rst_n = 1; halt = 0; redirect = 0; redirect_pc = 0; instr_ready = 0;
    cyc();
    chk_en = 1;

    // Streaming with constant instruction, 1-cycle memory.
    const_data = 1; mem_lat = 1; instr_ready = 1;
    reset_dut();
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (instr_valid) hit = 1; else cyc();
    end
    if (!hit) timeout("t1_first_valid");
    chk("t1_rs1", {27'd0, rs1_reg_offset}, 32'd1);
    chk("t1_rs2", {27'd0, rs2_reg_offset}, 32'd2);
    chk("t1_rd", {27'd0, rd_reg_offset}, 32'd0);
    chk("t1_freeze", {31'd0, freeze_pc}, 32'd0);
    wait_pops(3, "t1_pops");
    if (popped.size() >= 3 && req_log.size() >= 3) begin
      chk("t1_pop0", popped[0], 32'h0);
      chk("t1_pop1", popped[1], 32'h4);
      chk("t1_pop2", popped[2], 32'h8);
      chk("t1_req2", req_log[2], 32'h8);
    end

    // Backpressure: buffer fills to DEPTH and fetching stops.
    const_data = 0; instr_ready = 0;
    reset_dut();
    repeat (12) cyc();
    chk("t2_acks", ack_cnt, 32'd2);
    chk("t2_req", {31'd0, imem_req}, 32'd0);
    chk("t2_valid", {31'd0, instr_valid}, 32'd1);
    chk("t2_freeze", {31'd0, freeze_pc}, 32'd1);
    chk("t2_head", instr_out, 32'h0020_8033);
    instr_ready = 1;
    wait_pops(2, "t2_pops");
    if (popped.size() >= 2) begin
      chk("t2_pop0", popped[0], 32'h0);
      chk("t2_pop1", popped[1], 32'h4);
    end

    // Redirect while the request to 0x8 is outstanding.
    mem_lat = 3;
    reset_dut();
    hit = 0;
    for (int i = 0; i < 60 && !hit; i++) begin
      if (imem_req && imem_addr == 32'h8) hit = 1; else cyc();
    end
    if (!hit) timeout("t3_req8");
    redirect = 1; redirect_pc = 32'h100;
    cyc();
    redirect = 0;
    base = req_log.size();
    pbase = popped.size();
    wait_pops(pbase + 1, "t3_pop");
    if (req_log.size() > base) chk("t3_req", req_log[base], 32'h100);
    if (popped.size() > pbase) chk("t3_pop", popped[pbase], 32'h100);
    hit = 0;
    foreach (popped[i]) if (popped[i] == 32'h8) hit = 1;
    chk("t3_no8", {31'd0, hit}, 32'd0);

    // Redirect coinciding with ack and pop.
    mem_lat = 2; instr_ready = 0;
    reset_dut();
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (imem_ack && imem_addr == 32'h4) hit = 1; else cyc();
    end
    if (!hit) timeout("t4_ack4");
    instr_ready = 1; redirect = 1; redirect_pc = 32'h200;
    cyc();
    redirect = 0; instr_ready = 0;
    chk("t4_valid", {31'd0, instr_valid}, 32'd0);
    chk("t4_npop", popped.size(), 32'd1);
    if (popped.size() >= 1) chk("t4_pop0", popped[0], 32'h0);
    instr_ready = 1;
    wait_pops(2, "t4_pop");
    if (popped.size() >= 2) chk("t4_pop1", popped[1], 32'h200);

    // Halt with one request outstanding.
    mem_lat = 3;
    reset_dut();
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (imem_req) hit = 1; else cyc();
    end
    if (!hit) timeout("t5_req");
    halt = 1;
    repeat (6) cyc();
    chk("t5_acks", ack_cnt, 32'd1);
    chk("t5_req", {31'd0, imem_req}, 32'd0);
    chk("t5_nreq", req_log.size(), 32'd1);
    chk("t5_valid", {31'd0, instr_valid}, 32'd0);
    chk("t5_freeze", {31'd0, freeze_pc}, 32'd1);
    halt = 0;
    #1;
    chk("t5_valid_rel", {31'd0, instr_valid}, 32'd1);
    chk("t5_pc_rel", instr_pc, 32'h0);

    // Wrap-around and misaligned redirect.
    mem_lat = 1;
    reset_dut();
    wait_reqs(2, "t6_warm");
    wait_idle("t6_idle");
    base = req_log.size();
    redirect = 1; redirect_pc = 32'hFFFF_FFFC;
    cyc();
    redirect = 0;
    chk("t6_req_n", {31'd0, imem_req}, 32'd0);
    cyc();
    chk("t6_req_n1", {31'd0, imem_req}, 32'd1);
    chk("t6_addr_n1", imem_addr, 32'hFFFF_FFFC);
    wait_reqs(base + 2, "t6_wrap");
    if (req_log.size() >= base + 2) chk("t6_wrap", req_log[base+1], 32'h0);
    wait_idle("t6_idle2");
    base = req_log.size();
    redirect = 1; redirect_pc = 32'h102;
    cyc();
    redirect = 0;
`ifdef FETCH_MISALIGN_CHECK_EN
    repeat (10) cyc();
    chk("t6_fault", {31'd0, fetch_fault}, 32'd1);
    chk("t6_noreq", req_log.size(), base);
    chk("t6_fvalid", {31'd0, instr_valid}, 32'd0);
`else
    wait_reqs(base + 1, "t6_mis");
    if (req_log.size() > base) chk("t6_mis", req_log[base], 32'h100);
    chk("t6_nofault", {31'd0, fetch_fault}, 32'd0);
`endif
    repeat (3) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
